// File: rtl/fp_pkg.sv
// Shared types and constants for the floating-point datapath.
package fp_pkg;

  // Operand classification after subnormal flush.
  typedef enum logic [2:0] {
    FpZero,
    FpNorm,
    FpInf,
    FpQnan,
    FpSnan
  } fp_class_e;

  // Bit positions inside the 4-bit {nv, of, uf, nx} flag vector.
  localparam int unsigned FLG_NV = 3;
  localparam int unsigned FLG_OF = 2;
  localparam int unsigned FLG_UF = 1;
  localparam int unsigned FLG_NX = 0;

  // Canonical quiet NaN, right-aligned in 64 bits; callers slice their width.
  function automatic logic [63:0] fp_canon_nan(input int unsigned exp_w,
                                               input int unsigned man_w);
    logic [63:0] r;
    r = ((64'd1 << exp_w) - 64'd1) << man_w;
    r = r | (64'd1 << (man_w - 1));
    return r;
  endfunction

  // Infinity with the given sign, right-aligned in 64 bits.
  function automatic logic [63:0] fp_inf(input logic sign, input int unsigned exp_w,
                                         input int unsigned man_w);
    logic [63:0] r;
    r = ((64'd1 << exp_w) - 64'd1) << man_w;
    r = r | (64'(sign) << (exp_w + man_w));
    return r;
  endfunction

  // Classify from field summaries; a zero exponent always reads as zero.
  function automatic fp_class_e fp_classify(input logic exp_ones, input logic exp_zero,
                                            input logic frac_zero, input logic frac_msb);
    fp_class_e c;
    if (exp_ones) begin
      if (frac_zero)     c = FpInf;
      else if (frac_msb) c = FpQnan;
      else               c = FpSnan;
    end else if (exp_zero) begin
      c = FpZero;
    end else begin
      c = FpNorm;
    end
    return c;
  endfunction

endpackage

// File: rtl/fp_round_rne.sv
// Normalise a raw significand product, round to nearest even, detect
// overflow/underflow and pack the result word.
module fp_round_rne
  import fp_pkg::*;
#(
  parameter int unsigned EXP_W = 8,
  parameter int unsigned MAN_W = 23,
  localparam int unsigned W    = 1 + EXP_W + MAN_W,
  localparam int unsigned PW   = 2 * MAN_W + 2
) (
  input  logic                   sign_i,
  input  logic signed [EXP_W+1:0] exp_i,
  input  logic [PW-1:0]          prod_i,
  output logic [W-1:0]           result_o,
  output logic [3:0]             flags_o
);

  localparam int unsigned EW2 = EXP_W + 2;
  localparam logic signed [EW2-1:0] ExpMax  = EW2'((1 << EXP_W) - 1);
  localparam logic signed [EW2-1:0] ExpZero = '0;
  localparam logic [63:0]           InfWide = fp_inf(1'b0, EXP_W, MAN_W);
  localparam logic [W-2:0]          InfMag  = InfWide[W-2:0];

  logic [PW-2:0]          norm;
  logic [MAN_W-1:0]       frac;
  logic                   guard;
  logic                   sticky;
  logic                   round_up;
  logic [MAN_W:0]         frac_rnd;
  logic signed [EW2-1:0]  exp_n;

  // Normalise so the hidden one sits just above bit PW-2, then round and pack.
  always_comb begin
    norm     = prod_i[PW-1] ? prod_i[PW-2:0] : {prod_i[PW-3:0], 1'b0};
    frac     = norm[PW-2 -: MAN_W];
    guard    = norm[MAN_W];
    sticky   = |norm[MAN_W-1:0];
    round_up = guard & (sticky | frac[0]);
    frac_rnd = {1'b0, frac} + (MAN_W + 1)'(round_up);
    // On carry-out frac_rnd's low bits are already zero; only the exponent moves.
    exp_n    = exp_i + $signed(EW2'(prod_i[PW-1])) + $signed(EW2'(frac_rnd[MAN_W]));

    flags_o = '0;
    if (exp_n >= ExpMax) begin
      result_o        = {sign_i, InfMag};
      flags_o[FLG_OF] = 1'b1;
      flags_o[FLG_NX] = 1'b1;
    end else if (exp_n <= ExpZero) begin
      result_o        = {sign_i, {(W - 1){1'b0}}};
      flags_o[FLG_UF] = 1'b1;
      flags_o[FLG_NX] = 1'b1;
    end else begin
      result_o        = {sign_i, exp_n[EXP_W-1:0], frac_rnd[MAN_W-1:0]};
      flags_o[FLG_NX] = guard | sticky;
    end
  end

endmodule

// File: rtl/fp_mul_pipe.sv
// Three-stage IEEE-754 multiplier with valid/ready flow control.
// S1 unpacks/classifies, S2 multiplies significands and resolves special
// cases, S3 rounds and registers the result.
module fp_mul_pipe
  import fp_pkg::*;
#(
  parameter int unsigned EXP_W = 8,
  parameter int unsigned MAN_W = 23,
  localparam int unsigned W    = 1 + EXP_W + MAN_W
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] product,
  output logic [3:0]   flags
);

  localparam int unsigned     EW2      = EXP_W + 2;
  localparam int unsigned     PW       = 2 * MAN_W + 2;
  localparam int unsigned     Bias     = (1 << (EXP_W - 1)) - 1;
  localparam logic [EW2-1:0]  BiasX    = EW2'(Bias);
  localparam logic [63:0]     NanWide  = fp_canon_nan(EXP_W, MAN_W);
  localparam logic [63:0]     InfWide  = fp_inf(1'b0, EXP_W, MAN_W);
  localparam logic [W-1:0]    CanonNan = NanWide[W-1:0];
  localparam logic [W-2:0]    InfMag   = InfWide[W-2:0];

  // Stage 1 state
  logic                   v1_q, v1_d;
  logic                   s1_sign_q, s1_sign_d;
  fp_class_e              s1_cls_a_q, s1_cls_a_d, s1_cls_b_q, s1_cls_b_d;
  logic signed [EW2-1:0]  s1_exp_q, s1_exp_d;
  logic [MAN_W:0]         s1_ma_q, s1_ma_d, s1_mb_q, s1_mb_d;
  // Stage 2 state
  logic                   v2_q, v2_d;
  logic                   s2_sign_q, s2_sign_d;
  logic signed [EW2-1:0]  s2_exp_q, s2_exp_d;
  logic [PW-1:0]          s2_prod_q, s2_prod_d;
  logic                   s2_spec_q, s2_spec_d;
  logic [W-1:0]           s2_spec_res_q, s2_spec_res_d;
  logic [3:0]             s2_spec_flg_q, s2_spec_flg_d;
  // Stage 3 state
  logic                   v3_q, v3_d;
  logic [W-1:0]           product_q, product_d;
  logic [3:0]             flags_q, flags_d;

  logic                   rdy1, rdy2, rdy3;
  logic [EXP_W-1:0]       ea, eb;
  logic [MAN_W-1:0]       fa, fb;
  fp_class_e              cls_a, cls_b;
  logic                   spec;
  logic [W-1:0]           spec_res;
  logic [3:0]             spec_flg;
  logic [W-1:0]           rnd_res;
  logic [3:0]             rnd_flg;

  // Field extraction and classification of the incoming operands.
  always_comb begin
    ea    = a[W-2:MAN_W];
    eb    = b[W-2:MAN_W];
    fa    = a[MAN_W-1:0];
    fb    = b[MAN_W-1:0];
    cls_a = fp_classify(&ea, ~|ea, ~|fa, fa[MAN_W-1]);
    cls_b = fp_classify(&eb, ~|eb, ~|fb, fb[MAN_W-1]);
  end

  // Special-case resolution from S1 classes, in priority order.
  always_comb begin
    spec     = 1'b1;
    spec_res = '0;
    spec_flg = '0;
    if (s1_cls_a_q == FpSnan || s1_cls_b_q == FpSnan) begin
      spec_res         = CanonNan;
      spec_flg[FLG_NV] = 1'b1;
    end else if (s1_cls_a_q == FpQnan || s1_cls_b_q == FpQnan) begin
      spec_res = CanonNan;
    end else if ((s1_cls_a_q == FpInf && s1_cls_b_q == FpZero) ||
                 (s1_cls_a_q == FpZero && s1_cls_b_q == FpInf)) begin
      spec_res         = CanonNan;
      spec_flg[FLG_NV] = 1'b1;
    end else if (s1_cls_a_q == FpInf || s1_cls_b_q == FpInf) begin
      spec_res = {s1_sign_q, InfMag};
    end else if (s1_cls_a_q == FpZero || s1_cls_b_q == FpZero) begin
      spec_res = {s1_sign_q, {(W - 1){1'b0}}};
    end else begin
      spec = 1'b0;
    end
  end

  fp_round_rne #(
    .EXP_W (EXP_W),
    .MAN_W (MAN_W)
  ) u_round (
    .sign_i   (s2_sign_q),
    .exp_i    (s2_exp_q),
    .prod_i   (s2_prod_q),
    .result_o (rnd_res),
    .flags_o  (rnd_flg)
  );

  // Stage handshake and next-state; each stage loads whenever it can hand off or is empty.
  always_comb begin
    rdy3 = ~v3_q | out_ready;
    rdy2 = ~v2_q | rdy3;
    rdy1 = ~v1_q | rdy2;

    v1_d          = v1_q;
    s1_sign_d     = s1_sign_q;
    s1_cls_a_d    = s1_cls_a_q;
    s1_cls_b_d    = s1_cls_b_q;
    s1_exp_d      = s1_exp_q;
    s1_ma_d       = s1_ma_q;
    s1_mb_d       = s1_mb_q;
    v2_d          = v2_q;
    s2_sign_d     = s2_sign_q;
    s2_exp_d      = s2_exp_q;
    s2_prod_d     = s2_prod_q;
    s2_spec_d     = s2_spec_q;
    s2_spec_res_d = s2_spec_res_q;
    s2_spec_flg_d = s2_spec_flg_q;
    v3_d          = v3_q;
    product_d     = product_q;
    flags_d       = flags_q;

    if (rdy1) begin
      v1_d = in_valid;
      if (in_valid) begin
        s1_sign_d  = a[W-1] ^ b[W-1];
        s1_cls_a_d = cls_a;
        s1_cls_b_d = cls_b;
        s1_exp_d   = $signed({2'b00, ea}) + $signed({2'b00, eb}) - $signed(BiasX);
        s1_ma_d    = {1'b1, fa};
        s1_mb_d    = {1'b1, fb};
      end
    end

    if (rdy2) begin
      v2_d = v1_q;
      if (v1_q) begin
        s2_sign_d     = s1_sign_q;
        s2_exp_d      = s1_exp_q;
        s2_prod_d     = PW'(s1_ma_q) * PW'(s1_mb_q);
        s2_spec_d     = spec;
        s2_spec_res_d = spec_res;
        s2_spec_flg_d = spec_flg;
      end
    end

    if (rdy3) begin
      v3_d = v2_q;
      if (v2_q) begin
        product_d = s2_spec_q ? s2_spec_res_q : rnd_res;
        flags_d   = s2_spec_q ? s2_spec_flg_q : rnd_flg;
      end
    end
  end

  // Pipeline registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      v1_q          <= 1'b0;
      s1_sign_q     <= 1'b0;
      s1_cls_a_q    <= FpZero;
      s1_cls_b_q    <= FpZero;
      s1_exp_q      <= '0;
      s1_ma_q       <= '0;
      s1_mb_q       <= '0;
      v2_q          <= 1'b0;
      s2_sign_q     <= 1'b0;
      s2_exp_q      <= '0;
      s2_prod_q     <= '0;
      s2_spec_q     <= 1'b0;
      s2_spec_res_q <= '0;
      s2_spec_flg_q <= '0;
      v3_q          <= 1'b0;
      product_q     <= '0;
      flags_q       <= '0;
    end else begin
      v1_q          <= v1_d;
      s1_sign_q     <= s1_sign_d;
      s1_cls_a_q    <= s1_cls_a_d;
      s1_cls_b_q    <= s1_cls_b_d;
      s1_exp_q      <= s1_exp_d;
      s1_ma_q       <= s1_ma_d;
      s1_mb_q       <= s1_mb_d;
      v2_q          <= v2_d;
      s2_sign_q     <= s2_sign_d;
      s2_exp_q      <= s2_exp_d;
      s2_prod_q     <= s2_prod_d;
      s2_spec_q     <= s2_spec_d;
      s2_spec_res_q <= s2_spec_res_d;
      s2_spec_flg_q <= s2_spec_flg_d;
      v3_q          <= v3_d;
      product_q     <= product_d;
      flags_q       <= flags_d;
    end
  end

  assign in_ready  = rdy1 & rst_n;
  assign out_valid = v3_q;
  assign product   = product_q;
  assign flags     = flags_q;

endmodule

// File: doc/fp_mul_pipe.md
Name: fp_mul_pipe

Overview:
- Parametrised, pipelined IEEE-754 binary floating-point multiplier. Next generation of the team's combinational fp32 multiplier.
- Adds generic exponent/mantissa widths, a 3-stage pipeline with valid/ready backpressure, round-to-nearest-even, overflow/underflow saturation and exception flags.
- Sits between the operand-fetch stage and the result writeback FIFO of the FP datapath.

Parameters:
- EXP_W, 8, exponent field width; bias = 2^(EXP_W-1)-1 is a derived localparam.
- MAN_W, 23, stored fraction width; total word width W = 1+EXP_W+MAN_W.

Ports:
- clk  in  1  single clock; all state updates on the rising edge.
- rst_n  in  1  reset, synchronous, active-low.
- in_valid  in  1  operand pair valid.
- in_ready  out  1  block accepts the operand pair this cycle.
- a  in  W  operand A: sign | exponent | fraction.
- b  in  W  operand B.
- out_valid  out  1  result valid.
- out_ready  in  1  consumer accepts the result.
- product  out  W  result.
- flags  out  4  {nv, of, uf, nx}: invalid, overflow, underflow, inexact. Valid with out_valid.

Behaviour:
- Reset (rst_n low at the clock edge): all stage valids, out_valid, product and flags go to 0. In-flight operations are discarded. in_ready is 0 while rst_n is low and 1 in the first cycle after release.
- Pipeline stages:
  - S1: unpack, classify (ZERO/NORM/INF/QNAN/SNAN), sign = sa^sb, biased exponent sum in EXP_W+2-bit signed arithmetic (ea+eb-bias).
  - S2: (MAN_W+1)x(MAN_W+1) significand multiply, special-case result carried alongside.
  - S3: normalise, round, pack, register into product/flags.
- Handshake:
  - rdy3 = !v3 | out_ready; rdy2 = !v2 | rdy3; rdy1 = !v1 | rdy2; in_ready = rdy1.
  - A transfer occurs when in_valid & in_ready.
  - Latency is 3 cycles from accept to out_valid with no backpressure; throughput is 1 per cycle.
  - Bubbles collapse: a stage loads whenever it is empty, even if a later stage is stalled.
  - While out_valid & !out_ready, product and flags hold stable.
- Subnormal inputs (exp=0, frac!=0) are flushed to signed zero before classification. This is not flagged.
- Special-case priority:
  - SNAN on either input -> canonical NaN, nv=1.
  - QNAN on either input -> canonical NaN.
  - INF x ZERO -> canonical NaN, nv=1.
  - INF -> signed inf.
  - ZERO -> signed zero.
  - All special cases have of=uf=nx=0 except where stated above.
- Canonical NaN: sign 0, exponent all ones, fraction MSB 1, rest 0 (0x7FC00000 at defaults).
- Normal path:
  - If the product MSB is set, shift right by 1 and increment the exponent.
  - Round to nearest even using guard bit and sticky (OR of all lower bits); nx = guard|sticky.
  - A rounding carry-out renormalises: fraction becomes 0, exponent increments.
- Final exponent >= 2^EXP_W-1 -> signed inf, of=1, nx=1.
- Final exponent <= 0 -> signed zero (flush-to-zero), uf=1, nx=1. No subnormal outputs are produced.
- Exponent arithmetic never wraps; the EXP_W+2-bit signed intermediate covers the full range.

Decomposition:
- Package fp_pkg holds:
  - fp class enum (ZERO, NORM, INF, QNAN, SNAN);
  - flag bit index constants (FLG_NV=3, FLG_OF=2, FLG_UF=1, FLG_NX=0);
  - canonical-NaN and inf constructor functions, parametrised by EXP_W/MAN_W.
- One combinational sub-module, fp_round_rne: normalise + RNE + over/underflow detection + pack, instantiated in S3.

Test Plan:
- 0x40400000 x 0x40200000 (3.0 x 2.5), out_ready=1 -> after 3 cycles product=0x40F00000, flags=0000.
- 0x3F800001 x 0x3F800001 -> product=0x3F800002 (RNE), flags=0001 (nx). Also run 0x3F800003 x 0x3F800003 to check tie/sticky handling against a reference model.
- Exception cases:
  - 0x7F000000 x 0x40000000 -> 0x7F800000, flags=0101.
  - 0x00800000 x 0x3F000000 -> 0x00000000, flags=0011.
  - 0x7F800000 x 0x80000000 -> 0x7FC00000, flags=1000.
  - 0x7F800001 x 0x3F800000 -> 0x7FC00000, flags=1000.
- Stream 8 random normal pairs back-to-back with out_ready=0 on cycles 4-7:
  - no result is lost or duplicated and order is preserved;
  - in_ready falls after 3 stages fill;
  - product stays stable during the stall.
- Assert rst_n=0 for one cycle with 2 operations in flight -> out_valid=0, product=0 next cycle; no stale result emerges afterwards; in_ready=1 one cycle after release.
- EXP_W=5, MAN_W=10 instance: 0x4200 x 0x4100 (3.0 x 2.5) -> 0x4780 after 3 cycles, flags=0000.
